// File: rtl/spi_master_tx.sv
// SPI master transmit shift stage: pulls 32-bit words from the TX FIFO and shifts
// them out MSB-first on sdo0 (standard) or sdo3..sdo0 (quad), one step per tx_edge.
module spi_master_tx (
  input  logic        clk,
  input  logic        rstn,
  input  logic        en,
  input  logic        tx_edge,
  input  logic        en_quad_in,
  input  logic [15:0] counter_in,
  input  logic        counter_in_upd,
  input  logic [31:0] data,
  input  logic        data_valid,
  output logic        data_ready,
  output logic        clk_en_o,
  output logic        tx_done,
  output logic        sdo0,
  output logic        sdo1,
  output logic        sdo2,
  output logic        sdo3
);

  typedef enum logic [1:0] {IDLE, TRANSMIT, WAIT} state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [15:0] r_target;
  logic        r_quad;
  logic [31:0] r_shift;
  logic [15:0] r_edge_cnt;
  logic [4:0]  r_word_cnt;
  logic        r_done;

  logic        w_load;
  logic        w_shift;
  logic        w_start;
  logic        w_edge_inc;
  logic        w_done;
  logic [15:0] w_idle_tgt;
  logic [15:0] w_edge_tgt;
  logic        w_word_end;

  // Idle target uses the live quad request; once running, the latched mode applies.
  assign w_idle_tgt = en_quad_in ? {2'b00, r_target[15:2]} : r_target;
  assign w_edge_tgt = r_quad     ? {2'b00, r_target[15:2]} : r_target;
  assign w_word_end = r_quad ? (r_word_cnt == 5'd7) : (r_word_cnt == 5'd31);

  always_comb begin
    w_next_state = r_state;
    data_ready   = 1'b0;
    w_load       = 1'b0;
    w_shift      = 1'b0;
    w_start      = 1'b0;
    w_edge_inc   = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        // Holding off while tx_done is high keeps it apart from data_ready.
        if (en && !r_done) begin
          if (w_idle_tgt == '0) begin
            w_done = 1'b1;
          end else if (data_valid) begin
            data_ready   = 1'b1;
            w_load       = 1'b1;
            w_start      = 1'b1;
            w_next_state = TRANSMIT;
          end
        end
      end
      TRANSMIT: begin
        if (tx_edge) begin
          w_edge_inc = 1'b1;
          if (r_edge_cnt + 16'd1 == w_edge_tgt) begin
            w_done       = 1'b1;
            w_next_state = IDLE;
          end else if (w_word_end) begin
            if (data_valid) begin
              data_ready = 1'b1;
              w_load     = 1'b1;
            end else begin
              w_next_state = WAIT;
            end
          end else begin
            w_shift = 1'b1;
          end
        end
      end
      WAIT: begin
        if (data_valid) begin
          data_ready   = 1'b1;
          w_load       = 1'b1;
          w_next_state = TRANSMIT;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_target   <= '0;
      r_quad     <= 1'b0;
      r_shift    <= '0;
      r_edge_cnt <= '0;
      r_word_cnt <= '0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_done  <= w_done;
      if (r_state == IDLE && counter_in_upd)
        r_target <= counter_in;
      if (w_start)
        r_quad <= en_quad_in;
      if (w_start)
        r_edge_cnt <= '0;
      else if (w_edge_inc)
        r_edge_cnt <= r_edge_cnt + 16'd1;
      if (w_load)
        r_word_cnt <= '0;
      else if (w_shift)
        r_word_cnt <= r_word_cnt + 5'd1;
      if (w_load)
        r_shift <= data;
      else if (w_shift)
        r_shift <= r_quad ? {r_shift[27:0], 4'b0000} : {r_shift[30:0], 1'b0};
    end
  end

  assign clk_en_o = (r_state == TRANSMIT);
  assign tx_done  = r_done;
  assign {sdo3, sdo2, sdo1, sdo0} = r_quad ? r_shift[31:28] : {3'b000, r_shift[31]};

endmodule

// File: doc/spi_master_tx.md
Name: spi_master_tx

Overview:
- Transmit shift stage of the SPI master. Sits directly downstream of the SPI clock generator.
- Consumes the generator's falling-edge strobe and drives its enable (clk_en_o).
- Accepts 32-bit words over a valid/ready handshake from the TX FIFO and shifts them out MSB-first on sdo0 (standard) or sdo3..sdo0 (quad).
- Signals completion with a one-cycle tx_done pulse.

Parameters:
- None. Word width is fixed at 32 and the bit counter is fixed at 16 bits.

Ports:
- clk  input  1  system clock
- rstn  input  1  reset, asynchronous, active-low
- en  input  1  start request, sampled in IDLE only
- tx_edge  input  1  one-cycle strobe from the clock generator's falling-edge output
- en_quad_in  input  1  1 = quad mode (4 bits per edge), 0 = standard; sampled at start
- counter_in  input  16  transfer length in bits
- counter_in_upd  input  1  latches counter_in into the target register
- data  input  32  TX word
- data_valid  input  1  TX word available
- data_ready  output  1  word accepted this cycle (combinational)
- clk_en_o  output  1  enable to the clock generator
- tx_done  output  1  one-cycle pulse at end of transfer
- sdo0..sdo3  output  1 each  serial data outputs

Behaviour:
- Reset: all outputs 0; state IDLE; shift register, bit counter and target all 0.
- Target register:
  - Written from counter_in on counter_in_upd in IDLE only; ignored in TRANSMIT and WAIT.
  - Edge target = counter_in (standard) or counter_in>>2 (quad), fixed at start from en_quad_in. Quad lengths that are not a multiple of 4 are truncated.
- States: IDLE, TRANSMIT, WAIT.
- IDLE:
  - en=1, target=0: tx_done=1 next cycle; stay IDLE; data_ready=0; no word consumed.
  - en=1, target!=0, data_valid=1: data_ready=1; load word into shift register; edge_cnt=0; word_cnt=0; go TRANSMIT.
  - en=1, target!=0, data_valid=0: wait in IDLE until data_valid=1.
- clk_en_o = 1 in TRANSMIT only (registered state decode).
- sdo mapping:
  - Standard: sdo0 = shift[31]; sdo1..sdo3 = 0.
  - Quad: {sdo3,sdo2,sdo1,sdo0} = shift[31:28].
  - The first bit/nibble is valid from the cycle after load, before the first rising SPI edge.
- TRANSMIT, on each tx_edge:
  - edge_cnt++.
  - If edge_cnt+1 == target: tx_done=1 next cycle; go IDLE; clk_en_o=0; sdo holds last value.
  - Else if the word is exhausted (32 edges standard, 8 edges quad):
    - data_valid=1: data_ready=1 and load the new word in the same cycle; stay TRANSMIT.
    - data_valid=0: go WAIT; clk_en_o=0.
  - Otherwise shift left by 1 (standard) or 4 (quad), filling with 0.
- TRANSMIT, cycles without tx_edge: no change.
- WAIT:
  - clk_en_o=0; sdo holds.
  - tx_edge is ignored. The clock generator parks with SPI clock low.
  - On data_valid: data_ready=1; load; return to TRANSMIT; edge_cnt continues.
- en deasserted mid-transfer is ignored; the transfer completes.
- Async reset mid-transfer: immediate return to reset values; the partial word is discarded.
- tx_done and data_ready are never asserted in the same cycle.

Test Plan:
- Standard, counter_in=8, data=0xA500_0000: sdo0 across falling edges = 1,0,1,0,0,1,0,1; tx_done pulses once after the 8th tx_edge; clk_en_o falls with it; exactly 1 data_ready.
- Quad, counter_in=16, data=0x1234_0000: {sdo3..sdo0} = 0x1,0x2,0x3,0x4; tx_done after the 4th tx_edge.
- Standard, counter_in=64, second word 0x8000_0001 presented 5 cycles late:
  - After the 32nd edge: WAIT, clk_en_o=0, no shifting.
  - On valid: data_ready=1 and the stream resumes with 1.
  - Total 2 data_ready and 1 tx_done.
- counter_in=0 with en=1, data_valid=1: tx_done after 1 cycle; data_ready stays 0; clk_en_o stays 0.
- counter_in_upd with counter_in=4 during a 32-bit transfer: ignored; the transfer runs all 32 edges.
- rstn low after 10 edges: all outputs 0 immediately; after release a new 8-bit transfer runs correctly.
